mem_rr_scheduler: RTL and testbench

MEM_RR_SCHEDULER -- requirements
Module: mem_rr_scheduler

---
 rtl/mem_rr_scheduler.sv | 120 ++++++++++++
 tb/tb_mem_rr_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_scheduler.sv
// Round-robin scheduler granting one of three requesters access to a shared memory bus,
// with a hold limit that preempts a long-running grantee when another requester is waiting.
module mem_rr_scheduler #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        requestingMemory,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [DATA_W-1:0] dataToMem1,
  input  logic [DATA_W-1:0] dataToMem2,
  input  logic [DATA_W-1:0] dataToMem3,
  input  logic              readWrite1,
  input  logic              readWrite2,
  input  logic              readWrite3,
  output logic [2:0]        grantedAccess,
  output logic              enabled,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataToMem,
  output logic              readWrite,
  output logic [2:0]        preempted
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_n;
  logic [2:0] grant_n, preempted_n;
  logic [7:0] hold_cnt, hold_cnt_n;
  logic [1:0] last_grant, last_grant_n;
  logic [1:0] cand1, cand2, cand3, win_idx;
  logic       grantee_req, other_req;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Search order starts just after the previous winner, so the last grantee ranks lowest.
  assign cand1 = next_idx(last_grant);
  assign cand2 = next_idx(cand1);
  assign cand3 = next_idx(cand2);
  assign win_idx = requestingMemory[cand1] ? cand1 :
                   requestingMemory[cand2] ? cand2 : cand3;

  assign grantee_req = |(requestingMemory & grantedAccess);
  assign other_req   = |(requestingMemory & ~grantedAccess);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_n      = state;
    grant_n      = grantedAccess;
    preempted_n  = '0;
    hold_cnt_n   = hold_cnt;
    last_grant_n = last_grant;
    unique case (state)
      IDLE: begin
        if (|requestingMemory) begin
          grant_n      = 3'b001 << win_idx;
          last_grant_n = win_idx;
          hold_cnt_n   = '0;
          state_n      = GRANT;
        end
      end
      GRANT: begin
        // A voluntary release takes precedence over the hold-limit preemption.
        if (!grantee_req) begin
          grant_n = '0;
          state_n = RELEASE;
        end else if (hold_cnt == HOLD_LAST && other_req) begin
          grant_n     = '0;
          preempted_n = grantedAccess;
          state_n     = RELEASE;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grantedAccess <= '0;
      preempted     <= '0;
      hold_cnt      <= '0;
      last_grant    <= 2'd2;
    end else begin
      state         <= state_n;
      grantedAccess <= grant_n;
      preempted     <= preempted_n;
      hold_cnt      <= hold_cnt_n;
      last_grant    <= last_grant_n;
    end
  end

  assign enabled = |grantedAccess;

  // The grant is one-hot or zero, so an AND-OR select yields 0 on an idle bus.
  always_comb begin
    address   = ({ADDR_W{grantedAccess[0]}} & addr1)
              | ({ADDR_W{grantedAccess[1]}} & addr2)
              | ({ADDR_W{grantedAccess[2]}} & addr3);
    dataToMem = ({DATA_W{grantedAccess[0]}} & dataToMem1)
              | ({DATA_W{grantedAccess[1]}} & dataToMem2)
              | ({DATA_W{grantedAccess[2]}} & dataToMem3);
    readWrite = (grantedAccess[0] & readWrite1)
              | (grantedAccess[1] & readWrite2)
              | (grantedAccess[2] & readWrite3);
  end

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Directed-vector bench for mem_rr_scheduler with MAX_HOLD=4; inputs change and outputs are
// sampled on the falling edge.
module tb_mem_rr_scheduler;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        requestingMemory = '0;
  logic [ADDR_W-1:0] addr1 = 8'h11, addr2 = 8'h22, addr3 = 8'h33;
  logic [DATA_W-1:0] dataToMem1 = 32'hA1A1_0001, dataToMem2 = 32'hB2B2_0002, dataToMem3 = 32'hC3C3_0003;
  logic              readWrite1 = 1'b1, readWrite2 = 1'b0, readWrite3 = 1'b1;
  logic [2:0]        grantedAccess, preempted;
  logic              enabled, readWrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataToMem;

  int vectors = 0;
  int miscompares = 0;

  mem_rr_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .requestingMemory(requestingMemory),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .dataToMem1(dataToMem1), .dataToMem2(dataToMem2), .dataToMem3(dataToMem3),
    .readWrite1(readWrite1), .readWrite2(readWrite2), .readWrite3(readWrite3),
    .grantedAccess(grantedAccess), .enabled(enabled), .address(address),
    .dataToMem(dataToMem), .readWrite(readWrite), .preempted(preempted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    requestingMemory = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    requestingMemory = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({grantedAccess, preempted, enabled} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: grant=%b preempted=%b enabled=%b, want 000/000/0",
               grantedAccess, preempted, enabled);
    end
    vectors++;
    if ({address, dataToMem, readWrite} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h data=%h rw=%b, want all 0", address, dataToMem, readWrite);
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      vectors++;
      if (grantedAccess !== 3'b000 || enabled !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_no_req: grant=%b enabled=%b, want 000/0", grantedAccess, enabled);
      end
    end
  endtask

  // Requester 0 wins first, drops, and requester 1 follows after two idle-bus cycles.
  task automatic test_basic_grant();
    logic [2:0] exp_g [5] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000};
    do_reset();
    requestingMemory = 3'b111;
    step();
    vectors++;
    if (grantedAccess !== 3'b001 || address !== 8'h11 || dataToMem !== 32'hA1A1_0001 ||
        readWrite !== 1'b1 || enabled !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_first: grant=%b addr=%h data=%h rw=%b en=%b, want 001/11/a1a10001/1/1",
               grantedAccess, address, dataToMem, readWrite, enabled);
    end
    requestingMemory = 3'b110;
    for (int i = 1; i < 5; i++) begin
      if (i == 4) requestingMemory = 3'b000;
      step();
      vectors++;
      if (grantedAccess !== exp_g[i]) begin
        miscompares++;
        $display("FAIL basic_seq[%0d]: grant=%b, want %b", i, grantedAccess, exp_g[i]);
      end
    end
  endtask

  // 0 and 1 both requesting: hold limit alternates them with preemption pulses.
  task automatic test_preempt();
    logic [2:0] exp_g [13] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
                               3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b001};
    logic [2:0] exp_p [13] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000,
                               3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};
    do_reset();
    requestingMemory = 3'b011;
    for (int i = 0; i < 13; i++) begin
      step();
      vectors++;
      if (grantedAccess !== exp_g[i] || preempted !== exp_p[i]) begin
        miscompares++;
        $display("FAIL preempt[%0d]: grant=%b preempted=%b, want %b/%b",
                 i, grantedAccess, preempted, exp_g[i], exp_p[i]);
      end
      if (exp_g[i] == 3'b000) begin
        vectors++;
        if (address !== '0 || enabled !== 1'b0) begin
          miscompares++;
          $display("FAIL preempt_bus[%0d]: addr=%h en=%b, want 00/0", i, address, enabled);
        end
      end
    end
  endtask

  task automatic test_hold_forever();
    do_reset();
    requestingMemory = 3'b100;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if (grantedAccess !== 3'b100 || preempted !== 3'b000 || address !== 8'h33) begin
        miscompares++;
        $display("FAIL hold_forever[%0d]: grant=%b preempted=%b addr=%h, want 100/000/33",
                 i, grantedAccess, preempted, address);
      end
    end
  endtask

  // Grantee drops exactly on the hold-limit edge while requester 1 waits.
  task automatic test_release_wins();
    logic [2:0] exp_g [3] = '{3'b000, 3'b000, 3'b010};
    do_reset();
    requestingMemory = 3'b011;
    repeat (4) step();
    requestingMemory = 3'b010;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (grantedAccess !== exp_g[i] || preempted !== 3'b000) begin
        miscompares++;
        $display("FAIL release_wins[%0d]: grant=%b preempted=%b, want %b/000",
                 i, grantedAccess, preempted, exp_g[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    requestingMemory = 3'b010;
    step();
    vectors++;
    if (grantedAccess !== 3'b010) begin
      miscompares++;
      $display("FAIL async_pre: grant=%b, want 010", grantedAccess);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (grantedAccess !== 3'b000 || enabled !== 1'b0 || address !== '0 || dataToMem !== '0) begin
      miscompares++;
      $display("FAIL async_drop: grant=%b en=%b addr=%h data=%h, want 000/0/00/0",
               grantedAccess, enabled, address, dataToMem);
    end
    requestingMemory = 3'b110;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vectors++;
    if (grantedAccess !== 3'b010 || address !== 8'h22) begin
      miscompares++;
      $display("FAIL async_first: grant=%b addr=%h, want 010/22", grantedAccess, address);
    end
  endtask

  // All three requesting: 4 grant cycles + 2 idle cycles per requester, rotating 0,1,2.
  task automatic test_back_to_back();
    logic [2:0] exp_g, exp_p;
    do_reset();
    requestingMemory = 3'b111;
    for (int c = 0; c < 60; c++) begin
      step();
      exp_g = ((c % 6) < 4) ? 3'(3'b001 << ((c / 6) % 3)) : 3'b000;
      exp_p = ((c % 6) == 4) ? 3'(3'b001 << ((c / 6) % 3)) : 3'b000;
      vectors++;
      if (grantedAccess !== exp_g || preempted !== exp_p) begin
        miscompares++;
        $display("FAIL b2b[%0d]: grant=%b preempted=%b, want %b/%b",
                 c, grantedAccess, preempted, exp_g, exp_p);
      end
      if (grantedAccess === 3'b000) begin
        vectors++;
        if ({address, dataToMem, readWrite} !== '0) begin
          miscompares++;
          $display("FAIL b2b_bus[%0d]: addr=%h data=%h rw=%b, want 0", c, address, dataToMem, readWrite);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_grant();
    test_preempt();
    test_hold_forever();
    test_release_wins();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
